// File: rtl/basic_mem.sv
// ---------------------------------------------------------------------------
// basic_mem
//   Word-organised single-port RAM with byte-lane write strobes, a registered
//   read port (one cycle of latency) and a registered request acknowledge.
//   Reads and writes may be issued in the same cycle. The read returns the
//   word as it was before that cycle's write lands.
//
// Parameters
//   XLEN   data and address width in bits
//   DEPTH  number of XLEN-bit words held in mem
//
// Ports
//   clk     single clock, every state change happens on its rising edge
//   rst_n   synchronous active-low reset (clears resp/ack, never mem)
//   r_v     read request valid
//   w_v     write request valid
//   adr     byte address; word index is adr[log2(DEPTH)+1:2]
//   data    write data, byte lane i on bits [8i+7:8i]
//   strobe  per-lane write enable
//   resp    read data, valid the cycle after a read request
//   ack     high for one cycle after every request cycle
// ---------------------------------------------------------------------------
module basic_mem #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16384
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [XLEN-1:0] adr,
  input  logic [XLEN-1:0] data,
  input  logic [3:0]      strobe,
  output logic [XLEN-1:0] resp,
  output logic            ack
);

  localparam int IdxW  = $clog2(DEPTH);
  localparam int Lanes = (XLEN / 8 < 4) ? (XLEN / 8) : 4;

  // Storage is never reset so that preloaded contents survive rst_n.
  logic [XLEN-1:0] mem [0:DEPTH-1];

  logic [IdxW-1:0] index;
  logic [XLEN-1:0] resp_q;
  logic            ack_q;
  logic            ack_d;

  // The two low address bits select a byte within the word and the bits
  // above the index make the address space wrap; neither affects behaviour.
  logic unusedAdrBits;
  assign unusedAdrBits = ^{adr[XLEN-1:IdxW+2], adr[1:0]};

  assign index = adr[IdxW+1:2];

  // Every request cycle produces exactly one cycle of ack.
  always_comb begin
    ack_d = r_v | w_v;
  end

  // Byte-lane writes. Gating on rst_n keeps requests issued during reset
  // from disturbing memory.
  always_ff @(posedge clk) begin
    if (rst_n && w_v) begin
      for (int i = 0; i < Lanes; i++) begin
        if (strobe[i]) begin
          mem[index][8*i +: 8] <= data[8*i +: 8];
        end
      end
    end
  end

  // Registered read port. The nonblocking read of mem sees the value from
  // before any write in the same edge, which gives read-before-write on a
  // combined request; resp holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= ack_d;
      if (r_v) begin
        resp_q <= mem[index];
      end
    end
  end

  assign resp = resp_q;
  assign ack  = ack_q;

endmodule

// File: tb/tb_basic_mem.sv
// ---------------------------------------------------------------------------
// tb_basic_mem
//   Self-checking bench for basic_mem. A word-array reference model follows
//   every clock cycle: it predicts resp/ack from the request rules (read the
//   old word, then merge the write under the strobe mask) and each cycle's
//   outputs are compared against that prediction with immediate assertions.
//   Directed scenarios cover preload reads, partial writes, combined
//   read/write, wrap and misalignment, reset mid-stream and idle hold,
//   followed by a randomized stream.
// ---------------------------------------------------------------------------
module tb_basic_mem;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16384;

  logic            clk;
  logic            rst_n;
  logic            r_v;
  logic            w_v;
  logic [XLEN-1:0] adr;
  logic [XLEN-1:0] data;
  logic [3:0]      strobe;
  logic [XLEN-1:0] resp;
  logic            ack;

  int testsRun;
  int testsFailed;

  // Reference model state.
  logic [31:0] modelMem [DEPTH];
  logic [31:0] expResp;
  logic        expAck;

  basic_mem #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .r_v    (r_v),
    .w_v    (w_v),
    .adr    (adr),
    .data   (data),
    .strobe (strobe),
    .resp   (resp),
    .ack    (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  function automatic int wordOf(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Drive one request cycle, advance the model across the edge, and check
  // both outputs shortly after the edge.
  task automatic applyStimulus(input string tag, input logic rv, input logic wv,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
    logic [31:0] mask;
    int          w;
    r_v    = rv;
    w_v    = wv;
    adr    = a;
    data   = d;
    strobe = s;
    @(posedge clk);
    w = wordOf(a);
    if (!rst_n) begin
      expResp = 32'h0;
      expAck  = 1'b0;
    end else begin
      expAck = rv | wv;
      if (rv) expResp = modelMem[w];
      if (wv) begin
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        modelMem[w] = (modelMem[w] & ~mask) | (d & mask);
      end
    end
    #1;
    checkOutput({tag, ".resp"}, resp, expResp);
    checkOutput({tag, ".ack"}, {31'h0, ack}, {31'h0, expAck});
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    modelMem[idx] = val;
    dut.mem[idx]  = val;
  endtask

  initial begin
    logic [31:0] ra;
    testsRun    = 0;
    testsFailed = 0;
    rst_n  = 1'b0;
    r_v    = 1'b0;
    w_v    = 1'b0;
    adr    = '0;
    data   = '0;
    strobe = '0;
    expResp = '0;
    expAck  = 1'b0;

    for (int i = 0; i < DEPTH; i++) preload(i, 32'h0);
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(0, 32'h0000_0013);
    preload(1, 32'hDEAD_BEEF);
    preload(2, 32'h1122_3344);
    preload(3, 32'h0000_0000);

    // Reset state, with a write request that must be ignored.
    applyStimulus("rst0", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus("rstW", 1'b1, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF);
    rst_n = 1'b1;

    // Preloaded reads.
    applyStimulus("rd1", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    checkOutput("rd1.val", resp, 32'hDEAD_BEEF);
    applyStimulus("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("rd0.val", resp, 32'h0000_0013);

    // Partial write then read-back of the next-cycle word.
    applyStimulus("pw", 1'b0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101);
    applyStimulus("pwRd", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    checkOutput("pwRd.val", resp, 32'h11BB_33DD);

    // Write with no strobes is acknowledged but changes nothing.
    applyStimulus("w0", 1'b0, 1'b1, 32'h8, 32'h0, 4'h0);
    applyStimulus("w0Rd", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    checkOutput("w0Rd.val", resp, 32'h11BB_33DD);

    // Combined read/write returns the old word.
    applyStimulus("rw", 1'b1, 1'b1, 32'hC, 32'h1234_5678, 4'hF);
    checkOutput("rw.old", resp, 32'h0000_0000);
    applyStimulus("rwRd", 1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
    checkOutput("rwRd.new", resp, 32'h1234_5678);

    // Write to address 0 behaves normally.
    applyStimulus("wa0", 1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);
    applyStimulus("wa0Rd", 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

    // Address wrap and misalignment.
    applyStimulus("wrap", 1'b1, 1'b0, 32'h0001_0004, 32'h0, 4'h0);
    checkOutput("wrap.val", resp, 32'hDEAD_BEEF);
    applyStimulus("misal", 1'b1, 1'b0, 32'h7, 32'h0, 4'h0);
    checkOutput("misal.val", resp, 32'hDEAD_BEEF);

    // Reset mid-stream: in-flight read is dropped, write is ignored.
    applyStimulus("strm0", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    rst_n = 1'b0;
    applyStimulus("rstA", 1'b1, 1'b1, 32'h4, 32'h5555_5555, 4'hF);
    applyStimulus("rstB", 1'b1, 1'b1, 32'h4, 32'h6666_6666, 4'hF);
    checkOutput("rstMem1", dut.mem[1], 32'hDEAD_BEEF);
    checkOutput("rstMem5", dut.mem[5], modelMem[5]);
    rst_n = 1'b1;
    applyStimulus("postRst", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    checkOutput("postRst.val", resp, 32'hDEAD_BEEF);

    // Idle: resp holds, ack low.
    for (int i = 0; i < 3; i++) applyStimulus("idle", 1'b0, 1'b0, 32'h8, 32'h0, 4'h0);
    checkOutput("idle.hold", resp, 32'hDEAD_BEEF);

    // Randomized stream over a small window plus aliased upper addresses.
    for (int i = 0; i < 400; i++) begin
      ra = {$urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0,
            16'($urandom_range(0, 63) * 4 + $urandom_range(0, 3))};
      if ($urandom_range(0, 40) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      applyStimulus("rand", 1'($urandom), 1'($urandom), ra, $urandom, 4'($urandom));
    end
    rst_n = 1'b1;

    // Sweep the window to expose any divergence left in memory.
    for (int i = 0; i < 64; i++) begin
      applyStimulus("sweep", 1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/basic_mem.md
BASIC_MEM -- requirements
Module: basic_mem

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data and address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16384, giving the number of XLEN-bit words stored (64 KiB).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port r_v, input, 1 bit: read request valid.
REQ-006 The block SHALL have port w_v, input, 1 bit: write request valid.
REQ-007 The block SHALL have port adr, input, XLEN bits: byte address of the request.
REQ-008 The block SHALL have port data, input, XLEN bits: write data, with byte lane i on bits [8i+7:8i].
REQ-009 The block SHALL have port strobe, input, 4 bits: byte-enable per write lane.
REQ-010 The block SHALL have port resp, output, XLEN bits: read data.
REQ-011 The block SHALL have port ack, output, 1 bit: request-complete indication.
REQ-012 Storage SHALL be an unpacked array named mem of DEPTH words of XLEN bits, indexed 0..DEPTH-1, so a bench can preload it hierarchically with $readmemh (one hex word per line, word 0 first).

Function
REQ-013 Word index SHALL be adr[log2(DEPTH)+1:2].
- adr[1:0] is ignored (no misaligned access support).
- Higher address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
REQ-014 Read: when r_v=1 at a rising edge (rst_n=1), resp SHALL equal mem[index] in the next cycle (one-cycle registered latency).
REQ-015 When no read is issued, resp SHALL hold its last value.
REQ-016 Write: when w_v=1 at a rising edge (rst_n=1), the block SHALL set mem[index] byte lane i to data lane i for every i with strobe[i]=1.
- Lanes with strobe[i]=0 are unchanged.
- strobe=0 with w_v=1 SHALL write nothing, but is still acknowledged.
REQ-017 ack SHALL be registered as (r_v | w_v) sampled at the previous edge: one cycle of ack per request cycle.
- Back-to-back requests SHALL give continuous ack.
- No back-pressure; a request is accepted every cycle.
REQ-018 r_v=1 and w_v=1 together SHALL perform both operations, with read-before-write: resp returns the pre-write word and the write lands in the same edge.
REQ-019 A read of the word written in the previous cycle SHALL return the new data.
REQ-020 Writes to address 0 SHALL be treated as ordinary writes; the block has no special handling for any address.
REQ-021 Inputs SHALL be treated as sampled only at the clock edge; no combinational path from inputs to outputs.

Reset
REQ-022 While rst_n=0 at a rising edge, the block SHALL set resp to 0 and ack to 0.
REQ-023 While rst_n=0, r_v and w_v SHALL be ignored: no memory write occurs.
REQ-024 Reset SHALL NOT clear mem; preloaded contents survive reset.
REQ-025 A request in flight when reset asserts SHALL be dropped: no ack after reset deasserts.
REQ-026 The first request SHALL be accepted at the first edge with rst_n=1.

Verification
REQ-027 Preload mem[0]=0x00000013 and mem[1]=0xDEADBEEF, release reset, r_v=1, adr=0x4 -> next cycle resp=0xDEADBEEF and ack=1; adr=0x0 -> resp=0x00000013.
REQ-028 Partial write: mem[2]=0x11223344, w_v=1, adr=0x8, data=0xAABBCCDD, strobe=4'b0101 -> a subsequent read of 0x8 returns 0x11BB33DD.
REQ-029 Simultaneous access: mem[3]=0x0, r_v=w_v=1, adr=0xC, data=0x12345678, strobe=4'hF -> resp=0x00000000 in that response cycle, then a read returns 0x12345678.
REQ-030 Wrap and misalignment: adr=0x00010004 (DEPTH=16384) and adr=0x7 both return mem[1].
REQ-031 Reset mid-operation: r_v=1 streaming, then rst_n=0 for 2 cycles -> resp=0 and ack=0 during reset, w_v=1 during reset leaves mem unchanged, and mem[1] still reads 0xDEADBEEF after release.
REQ-032 Idle: r_v=w_v=0 for 3 cycles -> ack=0 and resp holds its last value.
